csa_tree_pipe: RTL and testbench

- Parametrised, pipelined carry-save reduction tree built from layers of 3:2 compressors.
- Reduces N_OPS aligned partial products to a redundant sum/carry pair, with an optional final carry-propagate add.
- Sits between the Booth-4 partial-product generator and the product register. It is the successor of the single-bit compressor_3_2: full width, arbitrary operand count, a register per layer, and a valid/ready handshake.

---
 rtl/mult_pkg.sv | 37 +++
 rtl/csa_tree_pipe_layer.sv | 56 +++++
 rtl/csa_tree_pipe.sv | 110 +++++++++++
 tb/tb_csa_tree_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Sizing helpers shared by the multiplier datapath: CSA tree depth, per-layer
// row counts and the width that holds the full sum of all operands.
package mult_pkg;

    // Rows remaining after one layer of 3:2 compression (leftovers pass through).
    function automatic int csa_next(input int n);
        return 2 * (n / 3) + (n % 3);
    endfunction

    function automatic int csa_layers(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        for (int k = 0; k < 64; k++) begin
            if (r > 2) begin
                r = csa_next(r);
                l++;
            end
        end
        return l;
    endfunction

    function automatic int csa_rows(input int n, input int i);
        int r;
        r = n;
        for (int k = 0; k < i; k++) begin
            r = csa_next(r);
        end
        return r;
    endfunction

    function automatic int csa_out_w(input int width, input int n_ops);
        return width + $clog2(n_ops);
    endfunction

endpackage

// File: rtl/csa_tree_pipe_layer.sv
// One registered layer of the carry-save tree: rows are taken in index-order
// triples through vector 3:2 compressors; 1 or 2 leftover rows pass through.
module csa_layer
    import mult_pkg::*;
#(
    parameter int ROWS_IN = 3,
    parameter int W       = 8,
    localparam int ROWS_OUT = csa_next(ROWS_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  valid_i,
    input  logic [ROWS_IN*W-1:0]  rows_i,
    output logic                  valid_o,
    output logic [ROWS_OUT*W-1:0] rows_o
);

    localparam int NT = ROWS_IN / 3;
    localparam int NL = ROWS_IN % 3;

    logic [ROWS_OUT*W-1:0] rows_nxt;
    logic [ROWS_OUT*W-1:0] rows_q;
    logic                  valid_q;

    // Triple t produces sum at row 2t and shifted carry at row 2t+1;
    // the carry out of the top bit is dropped since the total never exceeds W bits.
    for (genvar t = 0; t < NT; t++) begin : g_tri
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        assign a = rows_i[(3*t)*W +: W];
        assign b = rows_i[(3*t+1)*W +: W];
        assign c = rows_i[(3*t+2)*W +: W];
        assign rows_nxt[(2*t)*W +: W]   = a ^ b ^ c;
        assign rows_nxt[(2*t+1)*W +: W] = ((a & b) | (a & c) | (b & c)) << 1;
    end

    for (genvar j = 0; j < NL; j++) begin : g_pass
        assign rows_nxt[(2*NT+j)*W +: W] = rows_i[(3*NT+j)*W +: W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rows_q  <= '0;
        end else if (en) begin
            valid_q <= valid_i;
            rows_q  <= rows_nxt;
        end
    end

    assign valid_o = valid_q;
    assign rows_o  = rows_q;

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save reduction of N_OPS aligned partial products into a
// redundant sum/carry pair, with an optional registered carry-propagate add.
module csa_tree_pipe
    import mult_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int N_OPS     = 9,
    parameter int FINAL_ADD = 1,
    localparam int OUT_W    = csa_out_w(WIDTH, N_OPS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_OPS*WIDTH-1:0] ops_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       sum_o,
    output logic [OUT_W-1:0]       carry_o,
    output logic [OUT_W-1:0]       result_o
);

    localparam int L = csa_layers(N_OPS);

    if (N_OPS < 3 || N_OPS > 32) begin : g_bad_n_ops
        $error("csa_tree_pipe: N_OPS must be in 3..32");
    end

    // Handshake: a set is taken on a rising edge where in_valid && in_ready;
    // an output is consumed on an edge where out_valid && out_ready. One global
    // enable moves every stage together, so a stalled output freezes the whole
    // pipe (bubbles included) and out_valid/data hold until out_ready is seen.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic [N_OPS*OUT_W-1:0] ops_ext;
    for (genvar k = 0; k < N_OPS; k++) begin : g_ext
        assign ops_ext[k*OUT_W +: OUT_W] = {{(OUT_W-WIDTH){1'b0}}, ops_i[k*WIDTH +: WIDTH]};
    end

    for (genvar i = 0; i < L; i++) begin : g_layer
        localparam int RIN  = csa_rows(N_OPS, i);
        localparam int ROUT = csa_rows(N_OPS, i + 1);

        logic [RIN*OUT_W-1:0]  rows_in;
        logic                  vin;
        logic [ROUT*OUT_W-1:0] rows_out;
        logic                  vout;

        if (i == 0) begin : g_first
            assign rows_in = ops_ext;
            assign vin     = in_valid;
        end else begin : g_next
            assign rows_in = g_layer[i-1].rows_out;
            assign vin     = g_layer[i-1].vout;
        end

        csa_layer #(
            .ROWS_IN (RIN),
            .W       (OUT_W)
        ) u_layer (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .valid_i (vin),
            .rows_i  (rows_in),
            .valid_o (vout),
            .rows_o  (rows_out)
        );
    end

    // The last layer always compresses exactly three rows: row 0 is sum, row 1 carry.
    logic [2*OUT_W-1:0] last_rows;
    logic               last_valid;
    assign last_rows  = g_layer[L-1].rows_out;
    assign last_valid = g_layer[L-1].vout;

    if (FINAL_ADD != 0) begin : g_fadd
        logic             v_q;
        logic [OUT_W-1:0] s_q;
        logic [OUT_W-1:0] c_q;
        logic [OUT_W-1:0] r_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                s_q <= '0;
                c_q <= '0;
                r_q <= '0;
            end else if (en) begin
                v_q <= last_valid;
                s_q <= last_rows[OUT_W-1:0];
                c_q <= last_rows[2*OUT_W-1:OUT_W];
                r_q <= last_rows[OUT_W-1:0] + last_rows[2*OUT_W-1:OUT_W];
            end
        end

        assign out_valid = v_q;
        assign sum_o     = s_q;
        assign carry_o   = c_q;
        assign result_o  = r_q;
    end else begin : g_no_fadd
        assign out_valid = last_valid;
        assign sum_o     = last_rows[OUT_W-1:0];
        assign carry_o   = last_rows[2*OUT_W-1:OUT_W];
        assign result_o  = '0;
    end

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Self-checking bench for csa_tree_pipe: scoreboard on the default 9x16 build
// plus directed checks on 3- and 17-operand builds without the final adder.
module tb_csa_tree_pipe;

    localparam int W  = 16;
    localparam int N  = 9;
    localparam int OW = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [N*W-1:0]    ops_i;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     sum_o;
    logic [OW-1:0]     carry_o;
    logic [OW-1:0]     result_o;

    logic              sw_valid;
    logic              sw_ready;
    logic              in_ready3;
    logic              out_valid3;
    logic [3*W-1:0]    ops3;
    logic [17:0]       sum3;
    logic [17:0]       carry3;
    logic [17:0]       result3;
    logic              in_ready17;
    logic              out_valid17;
    logic [17*W-1:0]   ops17;
    logic [20:0]       sum17;
    logic [20:0]       carry17;
    logic [20:0]       result17;

    csa_tree_pipe #(.WIDTH(W), .N_OPS(N), .FINAL_ADD(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ops_i(ops_i),
        .out_valid(out_valid), .out_ready(out_ready), .sum_o(sum_o), .carry_o(carry_o),
        .result_o(result_o)
    );

    csa_tree_pipe #(.WIDTH(W), .N_OPS(3), .FINAL_ADD(0)) dut3 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(in_ready3), .ops_i(ops3),
        .out_valid(out_valid3), .out_ready(sw_ready), .sum_o(sum3), .carry_o(carry3),
        .result_o(result3)
    );

    csa_tree_pipe #(.WIDTH(W), .N_OPS(17), .FINAL_ADD(0)) dut17 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(in_ready17), .ops_i(ops17),
        .out_valid(out_valid17), .out_ready(sw_ready), .sum_o(sum17), .carry_o(carry17),
        .result_o(result17)
    );

    // ---------------- clock / cycle counter ----------------
    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [OW-1:0] ref_sum(input logic [N*W-1:0] ops);
        logic [OW-1:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s = s + OW'(ops[k*W +: W]);
        return s;
    endfunction

    function automatic logic [N*W-1:0] rand_ops();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = 16'($urandom_range(0, 65535));
        return v;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [OW-1:0] exp_q[$];
    int            acc_q[$];
    logic          mon_en   = 1'b0;
    logic          hold_prev = 1'b0;
    logic [OW-1:0] prev_sum, prev_carry, prev_res;
    logic [OW-1:0] m_exp, m_sc;
    int            m_acc;
    int            n_out = 0;
    int            last_lat = 0;
    int            last_pop_cyc = 0;
    logic [OW-1:0] last_res = '0;
    logic [OW-1:0] last_sc  = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (hold_prev) begin
                check("stall_valid",  32'(out_valid), 32'(1));
                check("stall_sum",    32'(sum_o),     32'(prev_sum));
                check("stall_carry",  32'(carry_o),   32'(prev_carry));
                check("stall_result", 32'(result_o),  32'(prev_res));
            end
            if (rst) begin
                exp_q.delete();
                acc_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 32'(result_o), 32'(0));
                        check("unexpected_valid", 32'(out_valid), 32'(0));
                    end else begin
                        m_exp = exp_q.pop_front();
                        m_acc = acc_q.pop_front();
                        m_sc  = OW'(sum_o + carry_o);
                        check("result", 32'(result_o), 32'(m_exp));
                        check("sum_plus_carry", 32'(m_sc), 32'(m_exp));
                        last_lat     = cyc - m_acc;
                        last_pop_cyc = cyc;
                        last_res     = result_o;
                        last_sc      = m_sc;
                        n_out++;
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_sum(ops_i));
                    acc_q.push_back(cyc);
                end
            end
            hold_prev  = out_valid && !out_ready && !rst;
            prev_sum   = sum_o;
            prev_carry = carry_o;
            prev_res   = result_o;
        end
    end

    // ---------------- backpressure generator ----------------
    logic bp_mode = 1'b0;
    int   low_cnt = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (bp_mode) begin
            if (low_cnt > 0) begin
                out_ready = 1'b0;
                low_cnt--;
            end else if ($urandom_range(0, 2) == 0) begin
                out_ready = 1'b0;
                low_cnt = $urandom_range(0, 3);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [N*W-1:0] ops, output int acc, output int waits);
        in_valid = 1'b1;
        ops_i    = ops;
        waits    = 0;
        acc      = -1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                break;
            end
            waits++;
            @(posedge clk);
            #1;
        end
        if (acc < 0) check("send_timeout", 32'(waits), 32'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int target);
        for (int t = 0; t < 400; t++) begin
            if (n_out >= target) break;
            @(posedge clk);
        end
        if (n_out < target) check("drain_timeout", 32'(n_out), 32'(target));
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_sweep(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int   lat3, lat17, e3, e17;
        logic seen3, seen17;
        logic [17:0] sc3, r3;
        logic [20:0] sc17, r17;
        for (int k = 0; k < 3; k++)  ops3[k*W +: W]  = (k % 2 == 0) ? a : b;
        for (int k = 0; k < 17; k++) ops17[k*W +: W] = (k % 2 == 0) ? a : b;
        e3  = 2 * int'(a) + int'(b);
        e17 = 9 * int'(a) + 8 * int'(b);
        seen3 = 1'b0; seen17 = 1'b0; lat3 = -1; lat17 = -1;
        sc3 = '0; r3 = '1; sc17 = '0; r17 = '1;
        sw_valid = 1'b1;
        for (int t = 0; t <= 20; t++) begin
            @(negedge clk);
            if (t == 0) begin
                check({tag, "_ready3"},  32'(in_ready3),  32'(1));
                check({tag, "_ready17"}, 32'(in_ready17), 32'(1));
            end
            if (out_valid3 && !seen3) begin
                seen3 = 1'b1; lat3 = t; sc3 = 18'(sum3 + carry3); r3 = result3;
            end
            if (out_valid17 && !seen17) begin
                seen17 = 1'b1; lat17 = t; sc17 = 21'(sum17 + carry17); r17 = result17;
            end
            @(posedge clk);
            #1;
            sw_valid = 1'b0;
        end
        check({tag, "_lat3"},    32'(lat3),  32'(1));
        check({tag, "_res3"},    32'(r3),    32'(0));
        check({tag, "_sc3"},     32'(sc3),   32'(e3));
        check({tag, "_lat17"},   32'(lat17), 32'(6));
        check({tag, "_res17"},   32'(r17),   32'(0));
        check({tag, "_sc17"},    32'(sc17),  32'(e17));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc, waits, first_acc, n0;
        logic [N*W-1:0] v;

        rst = 1'b1; in_valid = 1'b1; ops_i = rand_ops(); out_ready = 1'b0;
        sw_valid = 1'b0; sw_ready = 1'b1; ops3 = '0; ops17 = '0;

        // reset held with in_valid high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'(0));
            check("rst_sum",       32'(sum_o),     32'(0));
            check("rst_carry",     32'(carry_o),   32'(0));
            check("rst_result",    32'(result_o),  32'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'(1));
        check("post_rst_out_valid", 32'(out_valid), 32'(0));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        mon_en = 1'b1;

        // all-ones operands
        n0 = n_out;
        send({N{16'hFFFF}}, acc, waits);
        wait_outs(n0 + 1);
        check("ones_latency", 32'(last_lat), 32'(5));
        check("ones_result",  32'(last_res), 32'(20'h8FFF7));
        check("ones_sc",      32'(last_sc),  32'(20'h8FFF7));

        // back-to-back streaming
        idle(2);
        n0 = n_out;
        first_acc = 0;
        for (int i = 0; i < 20; i++) begin
            send(rand_ops(), acc, waits);
            if (i == 0) first_acc = acc;
            check("stream_no_wait", 32'(waits), 32'(0));
        end
        wait_outs(n0 + 20);
        check("stream_count", 32'(n_out - n0), 32'(20));
        check("stream_span",  32'(last_pop_cyc - first_acc), 32'(24));
        check("stream_empty", 32'(exp_q.size()), 32'(0));

        // random backpressure with input gaps
        n0 = n_out;
        bp_mode = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send(rand_ops(), acc, waits);
            idle($urandom_range(0, 2));
        end
        bp_mode = 1'b0;
        out_ready = 1'b1;
        wait_outs(n0 + 30);
        check("bp_count", 32'(n_out - n0), 32'(30));
        check("bp_empty", 32'(exp_q.size()), 32'(0));

        // reset while three sets are in flight
        idle(8);
        n0 = n_out;
        for (int i = 0; i < 3; i++) send(rand_ops(), acc, waits);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) v[k*W +: W] = 16'(k + 1);
        send(v, acc, waits);
        wait_outs(n0 + 1);
        check("midrst_latency", 32'(last_lat), 32'(5));
        check("midrst_result",  32'(last_res), 32'(45));
        idle(10);
        check("midrst_count", 32'(n_out - n0), 32'(1));

        // FINAL_ADD=0 builds
        run_sweep(16'hFFFF, 16'hFFFF, "sweep_ones");
        run_sweep(16'hAAAA, 16'h5555, "sweep_alt");

        check("final_empty", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
